// File: rtl/apb_ctrl_pkg.sv
// Shared types and constants for the APB register-bank controller.
package apb_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ISSUE = 2'd2,
    RESP  = 2'd3
  } state_e;

  localparam int unsigned WAIT_CNT_W    = 4;
  localparam int unsigned PROT_PRIV_BIT = 0;

endpackage

// File: rtl/apb_reg_ctrl.sv
// APB4 slave controller: sequences one rd/wr strobe into a register bank per transfer,
// with programmable wait states and protocol/privilege pre-checks.
module apb_reg_ctrl
  import apb_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned WAIT_CYCLES = 0,
  parameter int unsigned PRIV_ONLY   = 0
) (
  input  logic                    pclk,
  input  logic                    rstn,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic [2:0]              pprot,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr,
  output logic [ADDR_WIDTH-1:0]   reg_addr,
  output logic                    reg_rd,
  output logic                    reg_wr,
  output logic [DATA_WIDTH/8-1:0] reg_strb,
  output logic [DATA_WIDTH-1:0]   reg_wdata,
  input  logic [DATA_WIDTH-1:0]   reg_rdata,
  input  logic                    reg_err
);

  localparam logic [WAIT_CNT_W-1:0] CntInit = WAIT_CNT_W'(WAIT_CYCLES);
  localparam logic [WAIT_CNT_W-1:0] CntOne  = WAIT_CNT_W'(1);

  state_e                state;
  logic [WAIT_CNT_W-1:0] cnt;
  logic                  write_q;
  logic                  fail_q;
  logic                  setup_fail;
  logic                  unused_prot;

  // Reads must not carry byte strobes; privileged-only mode rejects unprivileged accesses.
  assign setup_fail  = (!pwrite && (|pstrb)) ||
                       ((PRIV_ONLY != 0) && !pprot[PROT_PRIV_BIT]);
  assign unused_prot = ^pprot[2:1];

  always_ff @(posedge pclk) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      write_q   <= 1'b0;
      fail_q    <= 1'b0;
      prdata    <= '0;
      pready    <= 1'b0;
      pslverr   <= 1'b0;
      reg_addr  <= '0;
      reg_rd    <= 1'b0;
      reg_wr    <= 1'b0;
      reg_strb  <= '0;
      reg_wdata <= '0;
    end else begin
      reg_rd <= 1'b0;
      reg_wr <= 1'b0;
      unique case (state)
        IDLE: begin
          if (psel && !penable) begin
            reg_addr  <= paddr;
            reg_wdata <= pwdata;
            reg_strb  <= pstrb;
            write_q   <= pwrite;
            fail_q    <= setup_fail;
            if (WAIT_CYCLES > 0) begin
              cnt   <= CntInit;
              state <= WAIT;
            end else begin
              reg_wr <= pwrite && !setup_fail;
              reg_rd <= !pwrite && !setup_fail;
              state  <= ISSUE;
            end
          end
        end
        WAIT: begin
          if (!psel) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - CntOne;
            if (cnt == CntOne) begin
              reg_wr <= write_q && !fail_q;
              reg_rd <= !write_q && !fail_q;
              state  <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (!psel) begin
            state <= IDLE;
          end else begin
            pready  <= 1'b1;
            pslverr <= fail_q || reg_err;
            prdata  <= (!write_q && !fail_q && !reg_err) ? reg_rdata : '0;
            state   <= RESP;
          end
        end
        RESP: begin
          if (!psel || penable) begin
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
            state   <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_reg_ctrl.sv
// Directed self-checking bench for apb_reg_ctrl across three parameterisations.
module tb_apb_reg_ctrl;

  logic        pclk;
  logic        rstn;
  logic [2:0]  psel_v;
  logic        penable;
  logic        pwrite;
  logic [11:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;

  logic [31:0] prdata0, prdata3, prdata5;
  logic        pready0, pready3, pready5;
  logic        pslverr0, pslverr3, pslverr5;
  logic [11:0] addr0, addr3, addr5;
  logic        rd0, rd3, rd5;
  logic        wr0, wr3, wr5;
  logic [3:0]  strb0, strb3, strb5;
  logic [31:0] wdata0, wdata3, wdata5;

  int checks = 0;
  int errors = 0;
  int cur = 0;
  int rd_cnt[3];
  int wr_cnt[3];

  logic        s_pready, s_pslverr, s_rd, s_wr;
  logic [31:0] s_prdata;
  logic [3:0]  s_strb;

  function automatic logic [31:0] bank_rdata(input logic [11:0] a);
    return (a == 12'h008) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | {20'h0, a});
  endfunction

  apb_reg_ctrl #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .WAIT_CYCLES(0), .PRIV_ONLY(0)) dut0 (
    .pclk(pclk), .rstn(rstn), .psel(psel_v[0]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata0), .pready(pready0), .pslverr(pslverr0),
    .reg_addr(addr0), .reg_rd(rd0), .reg_wr(wr0), .reg_strb(strb0), .reg_wdata(wdata0),
    .reg_rdata(bank_rdata(addr0)), .reg_err(addr0 == 12'h100)
  );

  apb_reg_ctrl #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .WAIT_CYCLES(3), .PRIV_ONLY(0)) dut3 (
    .pclk(pclk), .rstn(rstn), .psel(psel_v[1]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata3), .pready(pready3), .pslverr(pslverr3),
    .reg_addr(addr3), .reg_rd(rd3), .reg_wr(wr3), .reg_strb(strb3), .reg_wdata(wdata3),
    .reg_rdata(bank_rdata(addr3)), .reg_err(addr3 == 12'h100)
  );

  apb_reg_ctrl #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .WAIT_CYCLES(5), .PRIV_ONLY(1)) dut5 (
    .pclk(pclk), .rstn(rstn), .psel(psel_v[2]), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot),
    .prdata(prdata5), .pready(pready5), .pslverr(pslverr5),
    .reg_addr(addr5), .reg_rd(rd5), .reg_wr(wr5), .reg_strb(strb5), .reg_wdata(wdata5),
    .reg_rdata(bank_rdata(addr5)), .reg_err(addr5 == 12'h100)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  always @(posedge pclk) begin
    if (rd0) rd_cnt[0] <= rd_cnt[0] + 1;
    if (wr0) wr_cnt[0] <= wr_cnt[0] + 1;
    if (rd3) rd_cnt[1] <= rd_cnt[1] + 1;
    if (wr3) wr_cnt[1] <= wr_cnt[1] + 1;
    if (rd5) rd_cnt[2] <= rd_cnt[2] + 1;
    if (wr5) wr_cnt[2] <= wr_cnt[2] + 1;
  end

  always_comb begin
    s_pready = pready0; s_pslverr = pslverr0; s_prdata = prdata0;
    s_rd = rd0; s_wr = wr0; s_strb = strb0;
    if (cur == 1) begin
      s_pready = pready3; s_pslverr = pslverr3; s_prdata = prdata3;
      s_rd = rd3; s_wr = wr3; s_strb = strb3;
    end else if (cur == 2) begin
      s_pready = pready5; s_pslverr = pslverr5; s_prdata = prdata5;
      s_rd = rd5; s_wr = wr5; s_strb = strb5;
    end
  end

  // Runs one transfer on DUT s; called and returns at #1 after a rising edge.
  task automatic apb_xfer(input int s, input logic wr, input logic [11:0] a,
                          input logic [31:0] d, input logic [3:0] st, input logic [2:0] pr,
                          output int low, output int strobe_at, output logic [3:0] strb_seen,
                          output logic [31:0] rdat, output logic err);
    bit done;
    cur = s;
    psel_v = 3'b000;
    psel_v[s] = 1'b1;
    penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = st; pprot = pr;
    @(posedge pclk); #1;
    penable = 1'b1;
    low = 0; strobe_at = -1; strb_seen = '0; rdat = '0; err = 1'b0; done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      if ((s_rd || s_wr) && strobe_at < 0) begin
        strobe_at = n;
        strb_seen = s_strb;
      end
      if (s_pready) begin
        done = 1'b1; rdat = s_prdata; err = s_pslverr;
      end else begin
        low++;
        @(posedge pclk); #1;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL xfer_timeout dut=%0d: pready never rose within 40 cycles", s);
    end
    @(posedge pclk); #1;
    psel_v = 3'b000; penable = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({pready0, pslverr0, rd0, wr0, pready3, pready5} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got %b required 000000",
               {pready0, pslverr0, rd0, wr0, pready3, pready5});
    end
    checks++;
    if (prdata0 !== 32'h0 || wdata0 !== 32'h0) begin
      errors++;
      $display("FAIL reset_data: prdata=%h wdata=%h required 0", prdata0, wdata0);
    end
    checks++;
    if (addr0 !== 12'h0 || strb0 !== 4'h0) begin
      errors++;
      $display("FAIL reset_addr_strb: addr=%h strb=%b required 0", addr0, strb0);
    end
  endtask

  task automatic test_write_w0();
    int low, sat, r0, w0; logic [3:0] sb; logic [31:0] rdat; logic err;
    r0 = rd_cnt[0]; w0 = wr_cnt[0];
    apb_xfer(0, 1'b1, 12'h004, 32'hA5A5_1234, 4'b0011, 3'b000, low, sat, sb, rdat, err);
    checks++;
    if (low !== 1) begin
      errors++; $display("FAIL w0_latency: low=%0d required 1", low);
    end
    checks++;
    if (sat !== 0 || sb !== 4'b0011) begin
      errors++; $display("FAIL w0_strobe_t1: at=%0d strb=%b required 0/0011", sat, sb);
    end
    checks++;
    if (wr_cnt[0] - w0 !== 1 || rd_cnt[0] - r0 !== 0) begin
      errors++;
      $display("FAIL w0_strobe_count: wr=%0d rd=%0d required 1/0",
               wr_cnt[0] - w0, rd_cnt[0] - r0);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++; $display("FAIL w0_pslverr: got %b required 0", err);
    end
    checks++;
    if (addr0 !== 12'h004 || wdata0 !== 32'hA5A5_1234) begin
      errors++;
      $display("FAIL w0_latched: addr=%h wdata=%h required 004/a5a51234", addr0, wdata0);
    end
  endtask

  task automatic test_read_wait3();
    int low, sat, r0; logic [3:0] sb; logic [31:0] rdat; logic err;
    r0 = rd_cnt[1];
    apb_xfer(1, 1'b0, 12'h008, 32'h0, 4'b0000, 3'b000, low, sat, sb, rdat, err);
    checks++;
    if (low !== 4 || sat !== 3) begin
      errors++; $display("FAIL w3_latency: low=%0d strobe_at=%0d required 4/3", low, sat);
    end
    checks++;
    if (rdat !== 32'hDEAD_BEEF || err !== 1'b0) begin
      errors++; $display("FAIL w3_rdata: prdata=%h err=%b required deadbeef/0", rdat, err);
    end
    checks++;
    if (rd_cnt[1] - r0 !== 1) begin
      errors++; $display("FAIL w3_rd_count: got %0d required 1", rd_cnt[1] - r0);
    end
  endtask

  task automatic test_read_bad_strb();
    int low, sat, r0; logic [3:0] sb; logic [31:0] rdat; logic err;
    r0 = rd_cnt[0];
    apb_xfer(0, 1'b0, 12'h008, 32'h0, 4'b0001, 3'b000, low, sat, sb, rdat, err);
    checks++;
    if (sat !== -1 || rd_cnt[0] - r0 !== 0) begin
      errors++;
      $display("FAIL badstrb_no_rd: strobe_at=%0d rd=%0d required -1/0", sat, rd_cnt[0] - r0);
    end
    checks++;
    if (err !== 1'b1 || rdat !== 32'h0) begin
      errors++; $display("FAIL badstrb_resp: err=%b prdata=%h required 1/0", err, rdat);
    end
  endtask

  task automatic test_priv();
    int low, sat, w0; logic [3:0] sb; logic [31:0] rdat; logic err;
    w0 = wr_cnt[2];
    apb_xfer(2, 1'b1, 12'h010, 32'h1111_2222, 4'b1111, 3'b000, low, sat, sb, rdat, err);
    checks++;
    if (wr_cnt[2] - w0 !== 0 || err !== 1'b1 || low !== 6) begin
      errors++;
      $display("FAIL priv_reject: wr=%0d err=%b low=%0d required 0/1/6",
               wr_cnt[2] - w0, err, low);
    end
    w0 = wr_cnt[2];
    apb_xfer(2, 1'b1, 12'h010, 32'h1111_2222, 4'b1111, 3'b001, low, sat, sb, rdat, err);
    checks++;
    if (wr_cnt[2] - w0 !== 1 || err !== 1'b0 || sat !== 5) begin
      errors++;
      $display("FAIL priv_accept: wr=%0d err=%b strobe_at=%0d required 1/0/5",
               wr_cnt[2] - w0, err, sat);
    end
  endtask

  task automatic test_back_to_back();
    int low, sat; logic [3:0] sb; logic [31:0] rdat; logic err;
    apb_xfer(0, 1'b1, 12'h100, 32'h5555_AAAA, 4'b1111, 3'b000, low, sat, sb, rdat, err);
    checks++;
    if (err !== 1'b1) begin
      errors++; $display("FAIL b2b_bank_err: got %b required 1", err);
    end
    checks++;
    if (pready0 !== 1'b0 || pslverr0 !== 1'b0) begin
      errors++;
      $display("FAIL b2b_resp_clear: pready=%b pslverr=%b required 0/0", pready0, pslverr0);
    end
    apb_xfer(0, 1'b0, 12'h000, 32'h0, 4'b0000, 3'b000, low, sat, sb, rdat, err);
    checks++;
    if (err !== 1'b0 || rdat !== 32'hC0DE_0000 || low !== 1) begin
      errors++;
      $display("FAIL b2b_read: err=%b prdata=%h low=%0d required 0/c0de0000/1", err, rdat, low);
    end
  endtask

  task automatic test_reset_in_wait();
    int w0, low, sat; logic [3:0] sb; logic [31:0] rdat; logic err;
    w0 = wr_cnt[2];
    cur = 2;
    psel_v = 3'b100; penable = 1'b0; pwrite = 1'b1; paddr = 12'h020;
    pwdata = 32'hCAFE_F00D; pstrb = 4'b1111; pprot = 3'b001;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    rstn = 1'b0;
    @(posedge pclk); #1;
    checks++;
    if ({pready5, pslverr5, rd5, wr5} !== 4'b0 || prdata5 !== 32'h0 || addr5 !== 12'h0 ||
        strb5 !== 4'h0 || wdata5 !== 32'h0) begin
      errors++;
      $display("FAIL rst_wait_outputs: flags=%b prdata=%h addr=%h strb=%b wdata=%h required 0",
               {pready5, pslverr5, rd5, wr5}, prdata5, addr5, strb5, wdata5);
    end
    rstn = 1'b1; psel_v = 3'b000; penable = 1'b0;
    repeat (8) @(posedge pclk);
    #1;
    checks++;
    if (wr_cnt[2] - w0 !== 0) begin
      errors++; $display("FAIL rst_wait_no_strobe: wr=%0d required 0", wr_cnt[2] - w0);
    end
    apb_xfer(2, 1'b1, 12'h020, 32'hCAFE_F00D, 4'b1111, 3'b001, low, sat, sb, rdat, err);
    checks++;
    if (wr_cnt[2] - w0 !== 1 || err !== 1'b0 || low !== 6 || wdata5 !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL rst_wait_recover: wr=%0d err=%b low=%0d wdata=%h required 1/0/6/cafef00d",
               wr_cnt[2] - w0, err, low, wdata5);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rstn = 1'b0; psel_v = 3'b000; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
    for (int i = 0; i < 3; i++) begin
      rd_cnt[i] = 0;
      wr_cnt[i] = 0;
    end
    repeat (3) @(posedge pclk);
    #1;
    test_reset();
    rstn = 1'b1;
    @(posedge pclk); #1;
    test_write_w0();
    test_read_wait3();
    test_read_bad_strb();
    test_priv();
    test_back_to_back();
    test_reset_in_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
